divide_unit: RTL

- Iterative 32/16 integer divider for the NeoCore 16x32 execute stage.
- Supports unsigned (UDIV) and signed (SDIV) division. It is the inverse of the 16x16 to 32 multiply path: the dividend arrives split as hi/lo 16-bit halves, and the block returns a 16-bit quotient and a 16-bit remainder.
- Multi-cycle, with a start/ready/done handshake so the pipeline can stall on it.

---
 rtl/divide_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/divide_unit.sv
// Iterative 32/16 signed/unsigned divider with a start/ready/done handshake.
// Restoring shift-subtract on magnitudes, STEPS_PER_CYCLE quotient bits per clock, signs fixed up at the end.
module divide_unit #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [15:0] dividend_hi,
  input  logic [15:0] dividend_lo,
  input  logic [15:0] divisor,
  output logic        ready,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero,
  output logic        overflow
);

  localparam int ITERS = 32 / STEPS_PER_CYCLE;

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_steps
    $error("divide_unit: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] quo_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [16:0] rem_q;
  logic [15:0] dvs_q;
  logic [4:0]  iter_q;
  logic        q_neg;
  logic        r_neg;
  logic        signed_q;
  logic        zero_q;

  // Operand magnitudes, evaluated combinationally for the accept edge.
  logic [31:0] dividend_full;
  logic [31:0] dividend_mag;
  logic [15:0] divisor_mag;
  logic        dividend_neg;
  logic        divisor_neg;

  assign dividend_full = {dividend_hi, dividend_lo};
  assign dividend_neg  = is_signed & dividend_hi[15];
  assign divisor_neg   = is_signed & divisor[15];
  assign dividend_mag  = dividend_neg ? (~dividend_full + 32'd1) : dividend_full;
  assign divisor_mag   = divisor_neg ? (~divisor + 16'd1) : divisor;

  logic [31:0] quo_step;
  logic [16:0] rem_step;

  always_comb begin
    logic [17:0] trial;
    // NOTE: blocking assignments here so each unrolled step sees the previous step's result;
    // every output gets a default first so no latch is inferred.
    quo_step = quo_q;
    rem_step = rem_q;
    trial    = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      trial = {rem_step, quo_step[31]} - {2'b00, dvs_q};
      if (trial[17]) rem_step = {rem_step[15:0], quo_step[31]};
      else           rem_step = trial[16:0];
      quo_step = {quo_step[30:0], ~trial[17]};
    end
  end

  logic [15:0] quo_fix;
  logic [15:0] rem_fix;
  logic        ovf_fix;

  // Negating only the low half is enough: the output is the low 16 bits of the true quotient.
  assign quo_fix = q_neg ? (~quo_q[15:0] + 16'd1) : quo_q[15:0];
  assign rem_fix = r_neg ? (~rem_q[15:0] + 16'd1) : rem_q[15:0];

  always_comb begin
    if (signed_q) ovf_fix = q_neg ? (quo_q > 32'h0000_8000) : (quo_q > 32'h0000_7FFF);
    else          ovf_fix = |quo_q[31:16];
  end

  // NOTE: all state and registered outputs use non-blocking assignments in this one clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      iter_q    <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      signed_q  <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            zero_q   <= (divisor == 16'd0);
            // A zero divisor keeps the raw dividend so its low half can be returned as remainder.
            quo_q    <= (divisor == 16'd0) ? dividend_full : dividend_mag;
            rem_q    <= '0;
            dvs_q    <= divisor_mag;
            q_neg    <= dividend_neg ^ divisor_neg;
            r_neg    <= dividend_neg;
            signed_q <= is_signed;
            iter_q   <= 5'(ITERS - 1);
            ready    <= 1'b0;
            state    <= (divisor == 16'd0) ? FIX : BUSY;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        BUSY: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          if (iter_q == 5'd0) state <= FIX;
          else                iter_q <= iter_q - 5'd1;
        end
        FIX: begin
          if (zero_q) begin
            quotient  <= 16'hFFFF;
            remainder <= quo_q[15:0];
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else begin
            quotient  <= quo_fix;
            remainder <= rem_fix;
            div_zero  <= 1'b0;
            overflow  <= ovf_fix;
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
